// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg: state codes, opcodes, mux encodings and opcode class for the
// multicycle MIPS control FSM.  Rev 1.0
`default_nettype none

package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic addi;
    logic ori;
    logic halt;
    logic illegal;
  } op_class_t;

  function automatic logic is_terminal(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
           (s == S_IWB)   || (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if: control bus between the multicycle FSM (master) and datapath (slave).
// Rev 1.0
`default_nettype none

interface multi_cycle_control_if #(
  parameter int CNT_W = 32
);
  logic             Run;
  logic [5:0]       Op;
  logic             Zero;
  logic             PCWr;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             ExtOp;
  logic [1:0]       PCSource;
  logic             Halted;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;
  logic [3:0]       State;

  modport master (
    input  Run, Op, Zero,
    output PCWr, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, Halted, IllegalOp, InstrCount, State
  );

  modport slave (
    output Run, Op, Zero,
    input  PCWr, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, Halted, IllegalOp, InstrCount, State
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_control_main_decoder.sv
// multi_cycle_control_main_decoder: combinational opcode to one-hot instruction class.
// Rev 1.0
`default_nettype none

module multi_cycle_control_main_decoder
  import multi_cycle_control_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  op_cls
);

  always_comb begin
    op_cls = '0;
    case (op)
      OP_RTYPE: op_cls.rtype   = 1'b1;
      OP_LW:    op_cls.lw      = 1'b1;
      OP_SW:    op_cls.sw      = 1'b1;
      OP_BEQ:   op_cls.beq     = 1'b1;
      OP_J:     op_cls.j       = 1'b1;
      OP_ADDI:  op_cls.addi    = 1'b1;
      OP_ORI:   op_cls.ori     = 1'b1;
      OP_HALT:  op_cls.halt    = 1'b1;
      default:  op_cls.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multicycle MIPS control FSM with Moore output decode, retired-instruction
// counter and sticky illegal-opcode flag.  Rev 1.0
`default_nettype none

module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  multi_cycle_control_if.master       bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  op_class_t        op_cls;

  multi_cycle_control_main_decoder u_main_decoder (
    .op     (bus.Op),
    .op_cls (op_cls)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Every terminal state is left on the following edge, so being in one means retiring.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (is_terminal(state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE:   if (bus.Run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_cls.rtype)                   state_d = S_EXEC;
        else if (op_cls.lw || op_cls.sw)    state_d = S_MEMADR;
        else if (op_cls.beq)                state_d = S_BRANCH;
        else if (op_cls.j)                  state_d = S_JUMP;
        else if (op_cls.addi || op_cls.ori) state_d = S_IEXEC;
        else if (op_cls.halt || op_cls.illegal) state_d = S_HALT;
        else                                state_d = S_IDLE;
        illegal_d = illegal_q | op_cls.illegal;
      end
      S_MEMADR: state_d = op_cls.sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP:
        state_d = bus.Run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWr     = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_REG;
    bus.ALUOp    = ALUOP_ADD;
    bus.ExtOp    = 1'b0;
    bus.PCSource = PCSRC_ALU;
    bus.Halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWr    = 1'b1;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SH2;
        bus.ExtOp   = 1'b1;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ExtOp   = 1'b1;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = ALUOP_SUB;
        bus.PCSource = PCSRC_ALUOUT;
        bus.PCWr     = bus.Zero;
      end
      S_JUMP: begin
        bus.PCSource = PCSRC_JUMP;
        bus.PCWr     = 1'b1;
      end
      // IR is only loaded in FETCH, so Op is stable here and picks addi vs. ori.
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ExtOp   = ~op_cls.ori;
        bus.ALUOp   = op_cls.ori ? ALUOP_OR : ALUOP_ADD;
      end
      S_IWB:   bus.RegWrite = 1'b1;
      S_HALT:  bus.Halted   = 1'b1;
      default: ;
    endcase
  end

  assign bus.State      = state_q;
  assign bus.InstrCount = cnt_q;
  assign bus.IllegalOp  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed + randomized instruction streams checked against a
// per-instruction state-path / control-table model.  Rev 1.0
`default_nettype none

module tb_multi_cycle_control;

  localparam int CW = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  multi_cycle_control_if #(.CNT_W(CW)) bus ();

  multi_cycle_control #(.CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int exp_count = 0;
  bit exp_illegal = 1'b0;
  int path [5];
  int plen;
  int mw_cycles;
  logic [5:0] legal_ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001101};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    for (int k = 0; k < 7; k++) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {bus.PCWr, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ExtOp,
            bus.PCSource, bus.Halted};
  endfunction

  // Control table by state name, as the datapath expects it.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op, input logic z);
    logic pcwr, iord, mr, mw, irw, rd, m2r, rw, srca, ext, hlt;
    logic [1:0] srcb, aluop, pcs;
    {pcwr, iord, mr, mw, irw, rd, m2r, rw, srca, ext, hlt} = '0;
    srcb = 2'b00; aluop = 2'b00; pcs = 2'b00;
    case (st)
      1:  begin mr = 1; irw = 1; srcb = 2'b01; pcwr = 1; end
      2:  begin srcb = 2'b11; ext = 1; end
      3:  begin srca = 1; srcb = 2'b10; ext = 1; end
      4:  begin mr = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iord = 1; end
      7:  begin srca = 1; aluop = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin srca = 1; aluop = 2'b01; pcs = 2'b01; pcwr = z; end
      10: begin pcs = 2'b10; pcwr = 1; end
      11: begin
        srca = 1; srcb = 2'b10;
        if (op == 6'b001000) begin ext = 1; aluop = 2'b00; end
        else                 begin ext = 0; aluop = 2'b11; end
      end
      12: rw = 1;
      13: hlt = 1;
      default: ;
    endcase
    return {pcwr, iord, mr, mw, irw, rd, m2r, rw, srca, srcb, aluop, ext, pcs, hlt};
  endfunction

  task automatic set_path(input logic [5:0] op);
    case (op)
      6'b000000:            begin path = '{1, 2, 7, 8, 0};  plen = 4; end
      6'b100011:            begin path = '{1, 2, 3, 4, 5};  plen = 5; end
      6'b101011:            begin path = '{1, 2, 3, 6, 0};  plen = 4; end
      6'b000100:            begin path = '{1, 2, 9, 0, 0};  plen = 3; end
      6'b000010:            begin path = '{1, 2, 10, 0, 0}; plen = 3; end
      6'b001000, 6'b001101: begin path = '{1, 2, 11, 12, 0}; plen = 4; end
      default:              begin path = '{1, 2, 13, 0, 0}; plen = 3; end
    endcase
  endtask

  // Starts at a negedge with the FSM in IDLE or a terminal state; Run takes run_after at step drop_i.
  task automatic do_instr(input logic [5:0] op, input bit run_after, input int drop_i, input int zmode);
    set_path(op);
    bus.Op = op;
    mw_cycles = 0;
    for (int i = 0; i < plen; i++) begin
      if (i == 0) bus.Run = 1'b1;
      if (i == drop_i) bus.Run = run_after;
      bus.Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(posedge Clk); #1;
      if (i == plen - 1 && !is_legal(op) && op != 6'b111111) exp_illegal = 1'b1;
      check("state", 32'(bus.State), 32'(path[i]));
      check("ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(path[i], op, bus.Zero)));
      check("illegal_flag", 32'(bus.IllegalOp), 32'(exp_illegal));
      if (path[i] == 1) check("count_at_fetch", 32'(bus.InstrCount), 32'(exp_count));
      mw_cycles += int'(bus.MemWrite);
      @(negedge Clk);
    end
    if (is_legal(op)) exp_count = (exp_count + 1) % (1 << CW);
    if (!run_after && is_legal(op)) begin
      @(posedge Clk); #1;
      check("idle_after_drop", 32'(bus.State), 32'd0);
      check("count_at_idle", 32'(bus.InstrCount), 32'(exp_count));
      @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.Run = 1'b0;
    bus.Op = 6'b000000;
    bus.Zero = 1'b0;
    @(negedge Clk); @(negedge Clk);
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
    check("rst_count", 32'(bus.InstrCount), 32'd0);
    check("rst_illegal", 32'(bus.IllegalOp), 32'd0);
    Reset = 1'b0;
    exp_count = 0;
    exp_illegal = 1'b0;
  endtask

  initial begin
    int gap;
    logic [5:0] rop;
    bit rrun;

    do_reset();

    // Directed: R-type, lw, sw, beq taken / not taken, j, addi, ori.
    do_instr(6'b000000, 1'b1, 1, -1);
    do_instr(6'b100011, 1'b1, 1, -1);
    do_instr(6'b101011, 1'b1, 1, -1);
    check("sw_memwrite_cycles", 32'(mw_cycles), 32'd1);
    do_instr(6'b000100, 1'b1, 1, 1);
    do_instr(6'b000100, 1'b1, 1, 0);
    do_instr(6'b000010, 1'b1, 1, -1);
    do_instr(6'b001000, 1'b1, 1, -1);
    do_instr(6'b001101, 1'b1, 1, -1);

    // Run dropped while in EXEC: RWB still happens, then IDLE for a 5-cycle gap.
    do_instr(6'b000000, 1'b0, 3, -1);
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      check("idle_gap", 32'(bus.State), 32'd0);
      @(negedge Clk);
    end
    do_instr(6'b001101, 1'b1, 1, -1);

    // Randomized stream; the 4-bit counter wraps along the way.
    for (int n = 0; n < 40; n++) begin
      rop  = legal_ops[$urandom_range(0, 6)];
      rrun = ($urandom_range(0, 3) != 0);
      do_instr(rop, rrun, 1 + int'($urandom_range(0, 1)), -1);
      if (!rrun) begin
        gap = int'($urandom_range(0, 2));
        for (int c = 0; c < gap; c++) begin
          @(posedge Clk); #1;
          check("idle_rand", 32'(bus.State), 32'd0);
          @(negedge Clk);
        end
      end
    end

    // halt opcode: absorbing, not counted, not illegal.
    do_instr(6'b111111, 1'b1, 1, -1);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      check("halt_stays", 32'(bus.State), 32'd13);
      check("halt_flag", 32'(bus.Halted), 32'd1);
      check("halt_count", 32'(bus.InstrCount), 32'(exp_count));
      check("halt_not_illegal", 32'(bus.IllegalOp), 32'd0);
      @(negedge Clk);
    end

    // Illegal opcode after reset.
    do_reset();
    do_instr(6'b010101, 1'b1, 1, -1);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk); #1;
      check("illegal_halt_state", 32'(bus.State), 32'd13);
      check("illegal_sticky", 32'(bus.IllegalOp), 32'd1);
      check("illegal_count", 32'(bus.InstrCount), 32'd0);
      @(negedge Clk);
    end

    // Reset asserted mid-MEMRD aborts immediately.
    do_reset();
    do_instr(6'b000000, 1'b1, 1, -1);
    set_path(6'b100011);
    bus.Op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      check("lw_partial_state", 32'(bus.State), 32'(path[i]));
      if (i == 0) check("lw_partial_count", 32'(bus.InstrCount), 32'd1);
      @(negedge Clk);
    end
    #2 Reset = 1'b1;
    #1;
    check("abort_state", 32'(bus.State), 32'd0);
    check("abort_memread", 32'(bus.MemRead), 32'd0);
    check("abort_ctrl", 32'(dut_ctrl()), 32'd0);
    check("abort_count", 32'(bus.InstrCount), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    bus.Run = 1'b0;
    @(posedge Clk); #1;
    check("post_abort_idle", 32'(bus.State), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control FSM for the team's multicycle MIPS datapath, the successor to the single-cycle CPU. It takes the opcode held in the datapath's instruction register and sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It drives every datapath mux select and write enable, and gates execution with the `Run` level used by the existing CPU top. It also tracks halt, illegal-opcode and retired-instruction status for the bench.

## Interface
- Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.
- Ports:
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `Run` in 1: level-sensitive run enable.
- `Op` in 6: opcode, IR[31:26]. Valid from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `PCWr` out 1: PC write enable.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1, `MemWrite` out 1: memory read and write strobes.
- `IRWrite` out 1: instruction register load enable.
- `RegDst` out 1: destination register select. 1 = rd, 0 = rt.
- `MemtoReg` out 1: register write-data select. 1 = MDR, 0 = ALUOut.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input select. 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B input select. 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `ALUOp` out 2: ALU operation. 00 = add, 01 = sub, 10 = use funct, 11 = or.
- `ExtOp` out 1: immediate extension. 1 = sign-extend, 0 = zero-extend.
- `PCSource` out 2: next-PC select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Halted` out 1: halt indication.
- `IllegalOp` out 1: sticky illegal-opcode flag.
- `InstrCount` out CNT_W: retired-instruction count.
- `State` out 4: current state, for debug.

## Operation
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12, HALT=13
  - Codes 14–15 are unreachable and must transition to IDLE.
- Outputs are Moore (functions of state only), except `PCWr` in BRANCH, which equals `Zero`. Every signal not listed for a state is 0.
  - IDLE, HALT: all control outputs 0.
  - FETCH: MemRead, IRWrite, ALUSrcB=01, PCWr=1.
  - DECODE: ALUSrcB=11, ExtOp=1. This computes the branch target.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWr=Zero.
  - JUMP: PCSource=10, PCWr=1.
  - IEXEC: ALUSrcA=1, ALUSrcB=10. addi: ExtOp=1, ALUOp=00. ori: ExtOp=0, ALUOp=11.
  - IWB: RegWrite=1.
- Transitions:
  - IDLE→FETCH when Run=1.
  - FETCH→DECODE always.
  - DECODE by Op:
    - 000000→EXEC
    - 100011 (lw) or 101011 (sw)→MEMADR
    - 000100 (beq)→BRANCH
    - 000010 (j)→JUMP
    - 001000 (addi) or 001101 (ori)→IEXEC
    - 111111 (halt)→HALT
    - any other Op→HALT, and IllegalOp is set.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB. EXEC→RWB. IEXEC→IWB.
  - Terminal states are MEMWB, MEMWR, RWB, IWB, BRANCH and JUMP. From a terminal state, go to FETCH if Run=1, otherwise IDLE.
  - HALT is absorbing until Reset. Halted=1 exactly while in HALT.
- IEXEC selects addi vs. ori from `Op`. `Op` is stable because IR is written only in FETCH.
- InstrCount increments by 1 on every clock edge that leaves a terminal state. It wraps modulo 2^CNT_W. halt and illegal opcodes are not counted.
- IllegalOp is sticky and is cleared only by Reset.

## Timing
- Reset (asynchronous): State=IDLE, all outputs 0, InstrCount=0, IllegalOp=0.
- First FETCH occurs on the first rising edge on which Run=1 while in IDLE.
- Cycles per instruction, FETCH through terminal state inclusive:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j: 3
  - halt: HALT is entered on the 3rd edge.
- Run is sampled only in IDLE and in terminal states. If Run drops mid-instruction, that instruction completes and the FSM then goes to IDLE.
- Reset asserted mid-instruction aborts immediately. No write enable may be high after the reset edge.

## Structure
- Shared include `mc_defs.vh` holds:
  - the state codes
  - the opcode constants
  - the ALUOp, ALUSrcB and PCSource encodings
- Sub-module `mc_main_decoder` is combinational. It maps `Op` to a one-hot class: rtype, lw, sw, beq, j, addi, ori, halt, illegal.
- The top holds the state register, the output decode, the counter and the flags.

## Test plan
- Reset, then Run=1, then Op=000000: states 1,2,7,8,1. RegWrite=1 and RegDst=1 only in RWB. InstrCount=1 after RWB.
- lw (100011) followed by sw (101011): lw visits 1,2,3,4,5 and sw visits 1,2,3,6. MemWrite is high for exactly 1 cycle. InstrCount=2.
- beq with Zero=1, then beq with Zero=0: PCWr is 1 in BRANCH for the first and 0 for the second. Each takes 3 cycles.
- Run dropped during EXEC: RWB still occurs, then State=0. After a 5-cycle gap with Run=1 again, FETCH occurs on the next edge.
- Op=111111: Halted=1 from cycle 3 and stays. Op=010101 after reset: HALT with IllegalOp=1. InstrCount is unchanged in both cases.
- Reset pulsed during MEMRD: State=0 and MemRead=0 before the next edge. InstrCount=0.
